exhaustive_sweeper: RTL and testbench
=====================================

// Module: exhaustive_sweeper
// PURPOSE
//  Hardware version of the lab's exhaustive input sweep: drives every value 0..2^WIDTH-1 onto a DUT input bus.
//  Waits SETTLE cycles per vector, then compares two DUT response buses (resp_a vs resp_b).
//  Counts mismatches and latches the first failing vector. Sits beside a combinational lab DUT on the FPGA top.
//  Needs no simulator loop; results map to LEDs/7-seg.
// PARAMETERS
//  WIDTH         5  number of DUT input bits; sweep length = 2^WIDTH vectors (1..16)
//  OUT_W         3  width of each compared response bus
//  SETTLE        1  cycles each vector is held before it is checked (>=1)
//  STOP_ON_FAIL  0  1: end the sweep at the first mismatch; 0: sweep every vector
// PORTS
//  clk             in   1        system clock, rising edge
//  rst_n           in   1        asynchronous, active-low reset
//  start           in   1        1-cycle request; accepted only in IDLE or DONE
//  abort           in   1        synchronous stop; returns to IDLE
//  resp_a          in   OUT_W    DUT response under test
//  resp_b          in   OUT_W    expected/golden response
//  vec_out         out  WIDTH    stimulus vector driven to the DUT
//  busy            out  1        high in SETTLE and CHECK
//  done            out  1        high in DONE; held until start or abort
//  pass            out  1        done && err_count==0
//  err_count       out  WIDTH+1  mismatch count, 0..2^WIDTH
//  first_fail_vec  out  WIDTH    vector of the first mismatch; valid when fail_seen
//  fail_seen       out  1        sticky: at least one mismatch in the current sweep
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0.
//  States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
//  IDLE/DONE + start:
//   - vec_out<=0; err_count, first_fail_vec, fail_seen, done<=0; go to SETTLE.
//  SETTLE:
//   - stay SETTLE cycles, holding vec_out stable, then go to CHECK.
//  CHECK (exactly 1 cycle): compare resp_a against resp_b.
//   - Mismatch: err_count+1; if !fail_seen, then first_fail_vec<=vec_out and fail_seen<=1.
//   - If vec_out==2^WIDTH-1, or (STOP_ON_FAIL && mismatch): go to DONE, vec_out held.
//   - Otherwise: vec_out<=vec_out+1 and go to SETTLE.
//   - vec_out never wraps.
//  Timing and counters:
//   - Each vector costs SETTLE+1 cycles.
//   - Full sweep: start accepted -> done=1 after 2^WIDTH*(SETTLE+1) cycles.
//   - err_count is WIDTH+1 bits, so it cannot overflow (max 2^WIDTH).
//  start while busy is ignored. start in DONE restarts a fresh sweep.
//  abort (any state):
//   - Next cycle: IDLE, busy=0, done=0, vec_out=0.
//   - err_count/first_fail_vec/fail_seen retain their values.
//   - abort wins over a simultaneous start.
//  CHECK on the last vector with abort high: abort wins, done is not asserted.
//  Reset mid-sweep: immediate IDLE with all outputs 0; no partial results survive.
// STRUCTURE
//  Shared package sweeper_pkg: state encodings (S_IDLE=2'd0, S_SETTLE=2'd1, S_CHECK=2'd2, S_DONE=2'd3)
//  and the helper function last_vec(WIDTH).
//  Sub-module settle_timer:
//   - load/tick interface, counter width $clog2(SETTLE+1).
//   - Asserts expired on the last SETTLE cycle.
//  The FSM, vector counter and result registers stay in exhaustive_sweeper.
// TESTING (WIDTH=5, OUT_W=3, SETTLE=1 unless stated)
//  1. Loopback resp_a=resp_b=vec_out[2:0]; start.
//     -> done=1 exactly 64 cycles after start; pass=1; err_count=0; fail_seen=0.
//  2. resp_a bit0 flipped when vec_out==13.
//     -> err_count=1; first_fail_vec=13; pass=0; vec_out=31 at done.
//  3. STOP_ON_FAIL=1, faults injected at vectors 7 and 20.
//     -> done after 8*2 cycles; vec_out=7; err_count=1; first_fail_vec=7.
//  4. SETTLE=3, loopback.
//     -> each vec_out value is stable for 4 cycles; done after 128 cycles.
//  5. abort at cycle 30; start pulsed during busy.
//     -> busy=0 and vec_out=0 one cycle after abort; the start pulse has no effect.
//  6. rst_n=0 mid-sweep, then a second start after done.
//     -> all outputs 0 immediately; the second sweep clears the prior err_count and fail_seen.

Source files
------------

// File: rtl/sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sweeper_pkg
// Purpose : Shared definitions for the exhaustive input sweeper: the sweep
//           state encoding and a helper that returns the final vector of a
//           sweep of a given input width.
// Rev     : 1.0  initial release
// ============================================================================
package sweeper_pkg;

  // Sweep sequencer states. The encoding is fixed so the state can be
  // brought out to debug LEDs and read without a decoder table.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Highest vector of a sweep over 'width' input bits (2^width - 1).
  function automatic int unsigned last_vec(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage : sweeper_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module  : settle_timer
// Purpose : Counts the cycles a stimulus vector is held before its response
//           is checked. 'load' arms the timer for a new vector, 'tick'
//           advances it once per cycle, and 'expired' is high during the last
//           of the SETTLE hold cycles.
// Ports   : clk     in  1  system clock, rising edge
//           rst_n   in  1  asynchronous active-low reset
//           load    in  1  arm the timer for a fresh hold period
//           tick    in  1  count one hold cycle
//           expired out 1  current cycle is the last hold cycle
// Rev     : 1.0  initial release
// ============================================================================
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int                c_cnt_w = $clog2(SETTLE + 1);
  // The counter starts at SETTLE-1 so that it reads zero on the last hold
  // cycle; the first hold cycle is the one right after the load.
  localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(SETTLE - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_load;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - c_cnt_w'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/exhaustive_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : exhaustive_sweeper
// Purpose : Drives every value 0..2^WIDTH-1 onto a combinational lab DUT,
//           holds each vector SETTLE cycles, then compares the DUT response
//           (resp_a) against a golden response (resp_b) for one cycle.
//           Counts mismatches and latches the first failing vector. All
//           outputs are registered so they can drive LEDs / 7-seg directly.
// Ports   : clk            in   1        system clock, rising edge
//           rst_n          in   1        asynchronous active-low reset
//           start          in   1        sweep request (IDLE or DONE only)
//           abort          in   1        synchronous stop back to IDLE
//           resp_a         in   OUT_W    response under test
//           resp_b         in   OUT_W    golden response
//           vec_out        out  WIDTH    stimulus vector
//           busy           out  1        sweep in progress
//           done           out  1        sweep finished, held until start/abort
//           pass           out  1        done with zero mismatches
//           err_count      out  WIDTH+1  mismatch count
//           first_fail_vec out  WIDTH    vector of the first mismatch
//           fail_seen      out  1        at least one mismatch this sweep
// Rev     : 1.0  initial release
// ============================================================================
module exhaustive_sweeper
  import sweeper_pkg::*;
#(
  parameter int WIDTH        = 5,
  parameter int OUT_W        = 3,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] resp_a,
  input  logic [OUT_W-1:0] resp_b,
  output logic [WIDTH-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             fail_seen
);

  localparam int               c_err_w = WIDTH + 1;
  localparam logic [WIDTH-1:0] c_last  = WIDTH'(last_vec(WIDTH));
  localparam logic             c_stop  = (STOP_ON_FAIL != 0);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_vec_nxt;
  logic [c_err_w-1:0]   w_err_nxt;
  logic [WIDTH-1:0]     w_ffv_nxt;
  logic                 w_fs_nxt;
  logic                 w_timer_load;
  logic                 w_timer_tick;
  logic                 w_expired;
  logic                 w_mismatch;

  assign w_mismatch = (resp_a != resp_b);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_timer_load),
    .tick    (w_timer_tick),
    .expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-result logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = vec_out;
    w_err_nxt    = err_count;
    w_ffv_nxt    = first_fail_vec;
    w_fs_nxt     = fail_seen;
    w_timer_load = 1'b0;
    w_timer_tick = 1'b0;

    if (abort) begin
      // Abort beats start and beats a final CHECK; the results gathered so
      // far are kept so the operator can still read them after stopping.
      w_state_nxt = S_IDLE;
      w_vec_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt  = S_SETTLE;
            w_vec_nxt    = '0;
            w_err_nxt    = '0;
            w_ffv_nxt    = '0;
            w_fs_nxt     = 1'b0;
            w_timer_load = 1'b1;
          end
        end

        S_SETTLE: begin
          w_timer_tick = 1'b1;
          if (w_expired) begin
            w_state_nxt = S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            w_err_nxt = err_count + c_err_w'(1);
            if (!fail_seen) begin
              w_ffv_nxt = vec_out;
              w_fs_nxt  = 1'b1;
            end
          end
          // The last vector ends the sweep with vec_out held, so the counter
          // never wraps back to zero.
          if ((vec_out == c_last) || (c_stop && w_mismatch)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt  = S_SETTLE;
            w_vec_nxt    = vec_out + WIDTH'(1);
            w_timer_load = 1'b1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs. Status flags are decoded from the next state so they
  // change on the same edge as the state itself.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else begin
      vec_out        <= w_vec_nxt;
      busy           <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CHECK);
      done           <= (w_state_nxt == S_DONE);
      pass           <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
      err_count      <= w_err_nxt;
      first_fail_vec <= w_ffv_nxt;
      fail_seen      <= w_fs_nxt;
    end
  end

endmodule : exhaustive_sweeper
`default_nettype wire

// File: tb/tb_exhaustive_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : tb_exhaustive_sweeper
// Purpose : Self-checking bench for exhaustive_sweeper. Three instances run
//           side by side: default parameters, STOP_ON_FAIL=1 and SETTLE=3.
//           Each DUT is looped back onto its own vector, with optional
//           single-bit faults on resp_a at chosen vectors. A reference model
//           predicts each sweep's final results when it is started; the
//           prediction is queued and compared when done rises.
// Rev     : 1.0  initial release
// ============================================================================
module tb_exhaustive_sweeper;

  localparam int c_n = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start     [c_n];
  logic       abort     [c_n];
  logic [2:0] resp_a    [c_n];
  logic [2:0] resp_b    [c_n];
  logic [4:0] vec_out   [c_n];
  logic       busy      [c_n];
  logic       done      [c_n];
  logic       pass      [c_n];
  logic [5:0] err_count [c_n];
  logic [4:0] ffv       [c_n];
  logic       fail_seen [c_n];
  int         fv1       [c_n];
  int         fv2       [c_n];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cycles;
    int err;
    int ffv;
    int fs;
    int pass;
    int vec;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < c_n; g++) begin : g_resp
    assign resp_b[g] = vec_out[g][2:0];
    assign resp_a[g] = vec_out[g][2:0] ^
                       {2'b00, ((int'(vec_out[g]) == fv1[g]) || (int'(vec_out[g]) == fv2[g]))};
  end

  exhaustive_sweeper #(.WIDTH(5), .OUT_W(3), .SETTLE(1), .STOP_ON_FAIL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .resp_a(resp_a[0]), .resp_b(resp_b[0]), .vec_out(vec_out[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .first_fail_vec(ffv[0]), .fail_seen(fail_seen[0])
  );

  exhaustive_sweeper #(.WIDTH(5), .OUT_W(3), .SETTLE(1), .STOP_ON_FAIL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .resp_a(resp_a[1]), .resp_b(resp_b[1]), .vec_out(vec_out[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .first_fail_vec(ffv[1]), .fail_seen(fail_seen[1])
  );

  exhaustive_sweeper #(.WIDTH(5), .OUT_W(3), .SETTLE(3), .STOP_ON_FAIL(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .resp_a(resp_a[2]), .resp_b(resp_b[2]), .vec_out(vec_out[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_count[2]),
    .first_fail_vec(ffv[2]), .fail_seen(fail_seen[2])
  );

  function automatic int settle_of(input int idx);
    return (idx == 2) ? 3 : 1;
  endfunction

  function automatic bit stop_of(input int idx);
    return (idx == 1);
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference sweep: walk all 32 vectors, apply the fault list.
  function automatic exp_t model_sweep(input int idx);
    exp_t e;
    bit   mis;
    e = '{default: 0};
    for (int v = 0; v < 32; v++) begin
      mis      = (v == fv1[idx]) || (v == fv2[idx]);
      e.cycles += settle_of(idx) + 1;
      e.vec    = v;
      if (mis) begin
        e.err++;
        if (e.fs == 0) begin
          e.ffv = v;
          e.fs  = 1;
        end
      end
      if (stop_of(idx) && mis) break;
    end
    e.pass = int'(e.err == 0);
    return e;
  endfunction

  task automatic run_sweep(input int idx, input string name);
    exp_t       e;
    int         n;
    int         last_chg;
    int         bad_hold;
    logic [4:0] prev;
    sb_q.push_back(model_sweep(idx));
    @(negedge clk); start[idx] = 1'b1;
    @(negedge clk); start[idx] = 1'b0;
    check_eq({name, "_clr_err"},  int'(err_count[idx]), 0);
    check_eq({name, "_clr_fs"},   int'(fail_seen[idx]), 0);
    check_eq({name, "_clr_done"}, int'(done[idx]), 0);
    check_eq({name, "_busy"},     int'(busy[idx]), 1);
    check_eq({name, "_vec0"},     int'(vec_out[idx]), 0);
    n = 0; last_chg = 0; bad_hold = 0; prev = vec_out[idx];
    while (!done[idx] && n < 2000) begin
      @(negedge clk);
      n++;
      if (vec_out[idx] != prev) begin
        if (n - last_chg != settle_of(idx) + 1) bad_hold++;
        last_chg = n;
        prev     = vec_out[idx];
      end
    end
    e = sb_q.pop_front();
    check_eq({name, "_cycles"},    n, e.cycles);
    check_eq({name, "_err"},       int'(err_count[idx]), e.err);
    check_eq({name, "_ffv"},       int'(ffv[idx]), e.ffv);
    check_eq({name, "_fs"},        int'(fail_seen[idx]), e.fs);
    check_eq({name, "_pass"},      int'(pass[idx]), e.pass);
    check_eq({name, "_vec_end"},   int'(vec_out[idx]), e.vec);
    check_eq({name, "_busy_end"},  int'(busy[idx]), 0);
    check_eq({name, "_hold_bad"},  bad_hold, 0);
    repeat (3) @(negedge clk);
    check_eq({name, "_done_held"}, int'(done[idx]), 1);
  endtask

  initial begin
    for (int i = 0; i < c_n; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      fv1[i]   = -1;
      fv2[i]   = -1;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_vec",  int'(vec_out[0]), 0);
    check_eq("rst_busy", int'(busy[0]), 0);
    check_eq("rst_done", int'(done[0]), 0);
    check_eq("rst_pass", int'(pass[0]), 0);
    check_eq("rst_err",  int'(err_count[0]), 0);
    check_eq("rst_ffv",  int'(ffv[0]), 0);
    check_eq("rst_fs",   int'(fail_seen[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, then one fault at 13, then a clean restart from DONE
    run_sweep(0, "loop");
    fv1[0] = 13;
    run_sweep(0, "f13");
    fv1[0] = -1;
    run_sweep(0, "restart");

    // Stop on first fail, faults at 7 and 20
    fv1[1] = 7;
    fv2[1] = 20;
    run_sweep(1, "stop");

    // Longer settle
    run_sweep(2, "settle3");

    // Start during busy is ignored; abort at cycle 30 keeps results
    fv1[0] = 3;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 10) start[0] = 1'b1;
      if (n == 11) start[0] = 1'b0;
      if (n == 12) check_eq("busy_start_vec", int'(vec_out[0]), 6);
      if (n == 29) abort[0] = 1'b1;
      if (n == 30) begin
        abort[0] = 1'b0;
        check_eq("abort_busy", int'(busy[0]), 0);
        check_eq("abort_vec",  int'(vec_out[0]), 0);
        check_eq("abort_done", int'(done[0]), 0);
        check_eq("abort_err",  int'(err_count[0]), 1);
        check_eq("abort_fs",   int'(fail_seen[0]), 1);
        check_eq("abort_ffv",  int'(ffv[0]), 3);
      end
    end
    repeat (4) @(negedge clk);
    check_eq("abort_idle", int'(busy[0]), 0);

    // Abort and start together: abort wins
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check_eq("abort_vs_start_busy", int'(busy[0]), 0);
    check_eq("abort_vs_start_err",  int'(err_count[0]), 1);

    // Asynchronous reset mid-sweep
    fv1[0] = 2;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("mid_err", int'(err_count[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_vec",  int'(vec_out[0]), 0);
    check_eq("arst_busy", int'(busy[0]), 0);
    check_eq("arst_err",  int'(err_count[0]), 0);
    check_eq("arst_ffv",  int'(ffv[0]), 0);
    check_eq("arst_fs",   int'(fail_seen[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fv1[0] = -1;
    run_sweep(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_exhaustive_sweeper
`default_nettype wire
